pixel_combinator: RTL and testbench
===================================

PIXEL_COMBINATOR -- requirements
Module: pixel_combinator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, coordinate width.
REQ-002 SHALL have parameter RBG_SIZE, default 24, colour width.
REQ-003 SHALL have parameter NUM_QUEUES, default 4, number of engine reorder queues polled.
REQ-004 SHALL have parameter IMAGE_W, default 640, pixels per line.
REQ-005 SHALL have parameter IMAGE_H, default 480, lines per frame.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 1024, match-wait limit (used only under PIXEL_TIMEOUT_EN).
REQ-007 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-008 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port match_i  input  NUM_QUEUES  bit k: queue k front equals the check coordinate.
REQ-010 SHALL have port colour_i  input  NUM_QUEUES*RBG_SIZE  packed front colours, queue k at bits [k*RBG_SIZE +: RBG_SIZE].
REQ-011 SHALL have port xpixel_check  output  DATA_WIDTH  current raster x, broadcast to all queues.
REQ-012 SHALL have port ypixel_check  output  DATA_WIDTH  current raster y, broadcast to all queues.
REQ-013 SHALL have port pop_o  output  NUM_QUEUES  one-cycle pop strobe to the queue whose front was taken.
REQ-014 SHALL have ports out_data (output, RBG_SIZE), out_valid (output, 1), out_ready (input, 1): pixel stream, transfer when valid and ready both high.
REQ-015 SHALL have ports out_sop, out_eop  output  1  qualify out_data as pixel (0,0) / (IMAGE_W-1, IMAGE_H-1).
REQ-016 SHALL have ports frame_done (output, 1, one-cycle pulse) and error_o (output, 1, sticky error).

Function
REQ-017 SHALL implement two states: SCAN (await match) and OUT (present pixel).
REQ-018 In SCAN, if any match_i bit is high, SHALL select lowest index k, pulse pop_o[k] that cycle, register colour k into out_data, enter OUT next cycle.
REQ-019 SHALL raise out_valid exactly one cycle after the accepted match; out_data, out_sop, out_eop SHALL stay stable while out_valid is high and out_ready is low.
REQ-020 In OUT, SHALL ignore match_i, keep pop_o zero, and hold xpixel_check/ypixel_check unchanged.
REQ-021 On transfer in OUT, SHALL advance x by 1; at x = IMAGE_W-1, x wraps to 0 and y increments; at (IMAGE_W-1, IMAGE_H-1), both wrap to 0 and frame_done pulses in the transfer cycle; state returns to SCAN.
REQ-022 SHALL reach a maximum throughput of one pixel per two cycles.
REQ-023 If more than one match_i bit is high in SCAN, SHALL still take the lowest index and set error_o.
REQ-024 With no match in SCAN, SHALL stay in SCAN with out_valid low.
REQ-025 pop_o SHALL be one-hot or zero in every cycle.

Reset
REQ-026 On reset low, SHALL immediately enter SCAN; x, y, out_data, out_valid, out_sop, out_eop, pop_o, frame_done, error_o all 0.
REQ-027 Reset mid-frame SHALL drop any pending pixel without a pop, and restart scanning at (0,0) after reset deasserts.
REQ-028 error_o SHALL clear only by reset.

Configuration
REQ-029 With macro PIXEL_TIMEOUT_EN defined, SHALL count consecutive SCAN cycles with no match; on reaching TIMEOUT_CYCLES, SHALL emit out_data = 0 with no pop, set error_o, enter OUT, and clear the counter on each leaving SCAN.
REQ-030 Without PIXEL_TIMEOUT_EN, SHALL contain no timeout counter and SHALL wait in SCAN indefinitely.

Verification (IMAGE_W=4, IMAGE_H=2, NUM_QUEUES=2)
REQ-031 At (0,0), match_i=2'b10, colour1=24'hABCDEF, out_ready=1 -> pop_o=2'b10 for one cycle; next cycle out_valid=1, out_data=ABCDEF, out_sop=1; check coords become (1,0).
REQ-032 Hold out_ready=0 for 5 cycles after a match -> out_valid and out_data stay constant, pop_o=0, coords unchanged; out_ready=1 -> one transfer.
REQ-033 Feed 8 pixels in order -> coords walk (0,0)..(3,0),(0,1)..(3,1); out_eop plus frame_done on the 8th transfer; coords return to (0,0).
REQ-034 match_i=2'b11 in SCAN -> pop_o=2'b01, colour0 output, error_o=1 and stays 1.
REQ-035 Reset low while out_valid=1 at (2,1) -> all outputs 0 at once; after release, coords (0,0), no pop issued.
REQ-036 PIXEL_TIMEOUT_EN, TIMEOUT_CYCLES=8, no match -> after 8 SCAN cycles out_valid=1, out_data=0, pop_o=0, error_o=1; without the macro, no output after 100 cycles.

Source files
------------

// File: rtl/pixel_combinator.sv
// pixel_combinator: raster-order pixel gatherer polling engine reorder queues into one pixel stream.
// Optional match-wait timeout enabled by defining PIXEL_TIMEOUT_EN.
module pixel_combinator #(
  parameter int DATA_WIDTH     = 10,
  parameter int RBG_SIZE       = 24,
  parameter int NUM_QUEUES     = 4,
  parameter int IMAGE_W        = 640,
  parameter int IMAGE_H        = 480,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_QUEUES-1:0]          match_i,
  input  logic [NUM_QUEUES*RBG_SIZE-1:0] colour_i,
  output logic [DATA_WIDTH-1:0]          xpixel_check,
  output logic [DATA_WIDTH-1:0]          ypixel_check,
  output logic [NUM_QUEUES-1:0]          pop_o,
  output logic [RBG_SIZE-1:0]            out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_sop,
  output logic                           out_eop,
  output logic                           frame_done,
  output logic                           error_o
);
  typedef enum logic {SCAN, OUT} state_t;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [RBG_SIZE-1:0] data_q, data_d, col;
  logic [NUM_QUEUES-1:0] sel;
  logic err_q, err_d, any, multi, last_x, last_y, timeout;

  always_comb begin
    col = '0;
    for (int k = NUM_QUEUES - 1; k >= 0; k--)
      if (match_i[k]) col = colour_i[k*RBG_SIZE +: RBG_SIZE];
  end

`ifdef PIXEL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    timeout = (state_q == SCAN) && !any && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    cnt_d   = ((state_q == SCAN) && !any && !timeout) ? cnt_q + CW'(1) : '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
`else
  logic unused_timeout_cfg;
  always_comb begin
    timeout            = 1'b0;
    unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  end
`endif

  always_comb begin
    any    = |match_i;
    sel    = match_i & (~match_i + NUM_QUEUES'(1));
    multi  = |(match_i & (match_i - NUM_QUEUES'(1)));
    last_x = x_q == DATA_WIDTH'(IMAGE_W - 1);
    last_y = y_q == DATA_WIDTH'(IMAGE_H - 1);
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    data_d  = data_q;
    err_d   = err_q;
    if (state_q == SCAN) begin
      if (any || timeout) begin
        state_d = OUT;
        data_d  = any ? col : '0;
        err_d   = err_q | multi | timeout;
      end
    end else if (out_ready) begin
      state_d = SCAN;
      x_d     = last_x ? '0 : x_q + DATA_WIDTH'(1);
      y_d     = last_x ? (last_y ? '0 : y_q + DATA_WIDTH'(1)) : y_q;
    end
    // reset gates the strobe so no queue is popped while held in reset
    pop_o        = (reset && state_q == SCAN) ? sel : '0;
    out_valid    = state_q == OUT;
    out_sop      = out_valid && x_q == '0 && y_q == '0;
    out_eop      = out_valid && last_x && last_y;
    frame_done   = out_eop && out_ready;
    out_data     = data_q;
    error_o      = err_q;
    xpixel_check = x_q;
    ypixel_check = y_q;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= SCAN;
      x_q     <= '0;
      y_q     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
endmodule

// File: tb/tb_pixel_combinator.sv
// tb_pixel_combinator: directed table-driven bench for pixel_combinator on a 4x2 image with two queues.
module tb_pixel_combinator;
  localparam int DW = 10, RS = 24, NQ = 2, W = 4, H = 2, TO = 8;
  logic clk = 0, reset = 0, out_ready = 0;
  logic [NQ-1:0] match_i = '0;
  logic [NQ*RS-1:0] colour_i = '0;
  logic [DW-1:0] xpixel_check, ypixel_check;
  logic [NQ-1:0] pop_o;
  logic [RS-1:0] out_data;
  logic out_valid, out_sop, out_eop, frame_done, error_o;
  int n_chk = 0, n_fail = 0;

  pixel_combinator #(.DATA_WIDTH(DW), .RBG_SIZE(RS), .NUM_QUEUES(NQ), .IMAGE_W(W), .IMAGE_H(H),
                     .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .match_i(match_i), .colour_i(colour_i),
    .xpixel_check(xpixel_check), .ypixel_check(ypixel_check), .pop_o(pop_o),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop), .frame_done(frame_done), .error_o(error_o));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] m; logic [23:0] c0, c1;
    logic [1:0] pop; logic [23:0] data; int x, y; logic sop, eop, err;
  } vec_t;
  vec_t v[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic feed(input logic [23:0] c0);
    @(posedge clk) #1;
    match_i = 2'b01; colour_i = {24'h0, c0}; out_ready = 1;
    @(posedge clk) #1;
    match_i = 2'b00;
  endtask

  initial begin
    int seen;
    v[0] = '{2'b10, 24'h111111, 24'hABCDEF, 2'b10, 24'hABCDEF, 0, 0, 1, 0, 0};
    v[1] = '{2'b01, 24'h000001, 24'h222222, 2'b01, 24'h000001, 1, 0, 0, 0, 0};
    v[2] = '{2'b10, 24'h333333, 24'h444444, 2'b10, 24'h444444, 2, 0, 0, 0, 0};
    v[3] = '{2'b01, 24'h555555, 24'h666666, 2'b01, 24'h555555, 3, 0, 0, 0, 0};
    v[4] = '{2'b11, 24'h777777, 24'h888888, 2'b01, 24'h777777, 0, 1, 0, 0, 1};
    v[5] = '{2'b10, 24'h999999, 24'hAAAAAA, 2'b10, 24'hAAAAAA, 1, 1, 0, 0, 1};
    v[6] = '{2'b01, 24'hBBBBBB, 24'hCCCCCC, 2'b01, 24'hBBBBBB, 2, 1, 0, 0, 1};
    v[7] = '{2'b10, 24'hDDDDDD, 24'h123456, 2'b10, 24'h123456, 3, 1, 0, 1, 1};

    match_i = 2'b01;
    repeat (2) @(negedge clk);
    chk("rst_valid", out_valid, 0); chk("rst_pop", pop_o, 0); chk("rst_x", xpixel_check, 0);
    chk("rst_y", ypixel_check, 0); chk("rst_data", out_data, 0); chk("rst_err", error_o, 0);
    chk("rst_fd", frame_done, 0);
    @(posedge clk) #1;
    reset = 1; match_i = 0;

    for (int i = 0; i < 8; i++) begin
      @(posedge clk) #1;
      match_i = v[i].m; colour_i = {v[i].c1, v[i].c0}; out_ready = 1;
      @(negedge clk);
      chk($sformatf("v%0d_pop", i), pop_o, v[i].pop);
      chk($sformatf("v%0d_x", i), xpixel_check, v[i].x);
      chk($sformatf("v%0d_y", i), ypixel_check, v[i].y);
      chk($sformatf("v%0d_idle", i), out_valid, 0);
      @(posedge clk) #1;
      match_i = 0;
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_data", i), out_data, v[i].data);
      chk($sformatf("v%0d_sop", i), out_sop, v[i].sop);
      chk($sformatf("v%0d_eop", i), out_eop, v[i].eop);
      chk($sformatf("v%0d_fd", i), frame_done, v[i].eop);
      chk($sformatf("v%0d_err", i), error_o, v[i].err);
      chk($sformatf("v%0d_popout", i), pop_o, 0);
    end
    @(posedge clk) #1;
    @(negedge clk);
    chk("wrap_x", xpixel_check, 0); chk("wrap_y", ypixel_check, 0); chk("wrap_valid", out_valid, 0);

    // backpressure: pixel held five cycles, matches ignored meanwhile
    @(posedge clk) #1;
    match_i = 2'b01; colour_i = {24'h0, 24'h0F0F0F}; out_ready = 0;
    @(negedge clk);
    chk("bp_pop", pop_o, 2'b01);
    @(posedge clk) #1;
    match_i = 2'b11;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_valid", i), out_valid, 1);
      chk($sformatf("bp%0d_data", i), out_data, 24'h0F0F0F);
      chk($sformatf("bp%0d_pop", i), pop_o, 0);
      chk($sformatf("bp%0d_xy", i), {xpixel_check, ypixel_check}, 0);
      chk($sformatf("bp%0d_sop", i), out_sop, 1);
    end
    @(posedge clk) #1;
    match_i = 0; out_ready = 1;
    @(negedge clk);
    chk("bp_xfer_valid", out_valid, 1); chk("bp_xfer_fd", frame_done, 0); chk("bp_err", error_o, 1);
    @(posedge clk) #1;
    @(negedge clk);
    chk("bp_after_x", xpixel_check, 1); chk("bp_after_valid", out_valid, 0);

    // walk to (2,1), hold a pixel there, then reset asynchronously
    for (int i = 0; i < 5; i++) feed(24'h010101 * (i + 1));
    @(posedge clk) #1;
    match_i = 2'b01; colour_i = {24'h0, 24'h5A5A5A}; out_ready = 0;
    @(posedge clk) #1;
    @(negedge clk);
    chk("mid_valid", out_valid, 1); chk("mid_x", xpixel_check, 2); chk("mid_y", ypixel_check, 1);
    chk("mid_data", out_data, 24'h5A5A5A); chk("mid_err", error_o, 1);
    #1 reset = 0;
    #1;
    chk("ar_valid", out_valid, 0); chk("ar_data", out_data, 0); chk("ar_pop", pop_o, 0);
    chk("ar_sop", out_sop, 0); chk("ar_eop", out_eop, 0); chk("ar_fd", frame_done, 0);
    chk("ar_err", error_o, 0); chk("ar_xy", {xpixel_check, ypixel_check}, 0);
    @(posedge clk) #1;
    reset = 1; match_i = 0; out_ready = 1;
    @(negedge clk);
    chk("rel_xy", {xpixel_check, ypixel_check}, 0); chk("rel_pop", pop_o, 0);
    chk("rel_valid", out_valid, 0);

`ifdef PIXEL_TIMEOUT_EN
    seen = 0;
    for (int i = 1; i < TO; i++) begin
      @(negedge clk);
      seen += int'(out_valid);
    end
    chk("to_early_valid", seen, 0);
    @(negedge clk);
    chk("to_valid", out_valid, 1); chk("to_data", out_data, 0);
    chk("to_pop", pop_o, 0); chk("to_err", error_o, 1);
`else
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      seen += int'(out_valid) + int'(|pop_o);
    end
    chk("idle_activity", seen, 0); chk("idle_err", error_o, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
